min2_stream_finder: RTL and testbench



---
 rtl/min2_stream_finder_pkg.sv | 17 +
 rtl/min2_stream_finder_merge.sv | 23 ++
 rtl/min2_stream_finder.sv | 137 +++++++++++++
 tb/tb_min2_stream_finder.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/min2_stream_finder_pkg.sv
// ldpc_cn_pkg: shared widths, helpers and the min-pair triple for the check-node stages
package ldpc_cn_pkg;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction
  localparam int CN_W = 6;
  localparam int CN_MW = CN_W - 1;
  localparam int CN_IDXW = clog2(8 * 4);
  typedef struct packed {
    logic [CN_MW-1:0]   min1;
    logic [CN_MW-1:0]   min2;
    logic [CN_IDXW-1:0] idx;
  } cn_min2_t;
endpackage

// File: rtl/min2_stream_finder_merge.sv
// min2_merge: combinational merge of two (min1, min2, idx) pairs, "a" being the lower-index side
module min2_merge #(
  parameter int MW = 5,
  parameter int IW = 3
) (
  input  logic [MW-1:0] a1,
  input  logic [MW-1:0] a2,
  input  logic [IW-1:0] ai,
  input  logic [MW-1:0] b1,
  input  logic [MW-1:0] b2,
  input  logic [IW-1:0] bi,
  output logic [MW-1:0] m1,
  output logic [MW-1:0] m2,
  output logic [IW-1:0] mi
);
  logic gt;
  always_comb begin
    gt = a1 > b1;
    m1 = gt ? b1 : a1;
    m2 = gt ? (a1 < b2 ? a1 : b2) : (a2 < b1 ? a2 : b1);
    mi = gt ? bi : ai;
  end
endmodule

// File: rtl/min2_stream_finder.sv
// min2_stream_finder: multi-beat two-minimum finder with global min1 index and sign product
module min2_stream_finder
  import ldpc_cn_pkg::*;
#(
  parameter int W = 6,
  parameter int LANES = 8,
  parameter int MAX_BEATS = 4,
  parameter int IDXW = clog2(LANES * MAX_BEATS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic                     in_last,
  input  logic [LANES*(W-1)-1:0]   x,
  input  logic [LANES-1:0]         sgn,
  output logic [W-2:0]             min1,
  output logic [W-2:0]             min2,
  output logic [IDXW-1:0]          idx,
  output logic                     sign_prod,
  output logic                     out_valid,
  output logic                     overflow
);
  localparam int MW = W - 1;
  localparam int LW = clog2(LANES);
  localparam int BW = MAX_BEATS > 1 ? clog2(MAX_BEATS) : 1;

  // heap-ordered tree: node n merges 2n (lower lanes) with 2n+1; leaves carry an all-ones min2
  logic [2*LANES-1:1][MW-1:0] t1, t2;
  logic [2*LANES-1:1][LW-1:0] ti;

  for (genvar k = 0; k < LANES; k++) begin : g_leaf
    assign t1[LANES+k] = x[k*MW +: MW];
    assign t2[LANES+k] = '1;
    assign ti[LANES+k] = LW'(k);
  end

  for (genvar n = 1; n < LANES; n++) begin : g_node
    min2_merge #(.MW(MW), .IW(LW)) u_merge (
      .a1(t1[2*n]), .a2(t2[2*n]), .ai(ti[2*n]),
      .b1(t1[2*n+1]), .b2(t2[2*n+1]), .bi(ti[2*n+1]),
      .m1(t1[n]), .m2(t2[n]), .mi(ti[n])
    );
  end

  logic [BW-1:0] beat;
  logic          mid;
  logic          at_max, fin;
  logic          s1_v, s1_first, s1_last, s1_ovf, s1_sgn;
  logic [BW-1:0] s1_beat;
  logic [MW-1:0] s1_m1, s1_m2;
  logic [LW-1:0] s1_li;

  assign at_max = beat == BW'(MAX_BEATS - 1);
  assign fin = in_last || at_max;

  always_ff @(posedge clk) begin
    if (rst) begin
      beat <= '0;
      mid <= 1'b0;
      s1_v <= 1'b0;
      s1_first <= 1'b0;
      s1_last <= 1'b0;
      s1_ovf <= 1'b0;
      s1_sgn <= 1'b0;
      s1_beat <= '0;
      s1_m1 <= '0;
      s1_m2 <= '0;
      s1_li <= '0;
    end else begin
      s1_v <= in_valid;
      if (in_valid) begin
        s1_m1 <= t1[1];
        s1_m2 <= t2[1];
        s1_li <= ti[1];
        s1_sgn <= ^sgn;
        s1_beat <= beat;
        s1_first <= !mid;
        s1_last <= fin;
        s1_ovf <= !in_last && at_max;
        beat <= fin ? '0 : beat + BW'(1);
        mid <= !fin;
      end
    end
  end

  logic [IDXW-1:0] gidx, mgi, acc_i;
  logic [MW-1:0]   mg1, mg2, acc_m1, acc_m2;
  logic            acc_s, acc_done, acc_ovf;

  assign gidx = (IDXW'(s1_beat) << LW) | IDXW'(s1_li);

  min2_merge #(.MW(MW), .IW(IDXW)) u_acc (
    .a1(acc_m1), .a2(acc_m2), .ai(acc_i),
    .b1(s1_m1), .b2(s1_m2), .bi(gidx),
    .m1(mg1), .m2(mg2), .mi(mgi)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_m1 <= '0;
      acc_m2 <= '0;
      acc_i <= '0;
      acc_s <= 1'b0;
      acc_done <= 1'b0;
      acc_ovf <= 1'b0;
    end else begin
      acc_done <= s1_v && s1_last;
      acc_ovf <= s1_v && s1_ovf;
      if (s1_v) begin
        acc_m1 <= s1_first ? s1_m1 : mg1;
        acc_m2 <= s1_first ? s1_m2 : mg2;
        acc_i <= s1_first ? gidx : mgi;
        acc_s <= s1_first ? s1_sgn : acc_s ^ s1_sgn;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      overflow <= 1'b0;
      min1 <= '0;
      min2 <= '0;
      idx <= '0;
      sign_prod <= 1'b0;
    end else begin
      out_valid <= acc_done;
      overflow <= acc_ovf;
      if (acc_done) begin
        min1 <= acc_m1;
        min2 <= acc_m2;
        idx <= acc_i;
        sign_prod <= acc_s;
      end
    end
  end
endmodule

// File: tb/tb_min2_stream_finder.sv
// tb_min2_stream_finder: directed and random frames checked against a frame-level reference model
module tb_min2_stream_finder;
  import ldpc_cn_pkg::*;
  localparam int LANES = 8;
  localparam int MAXB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic [39:0] x = '0;
  logic [7:0] sgn = '0;
  logic [4:0] min1, min2;
  logic [4:0] idx;
  logic sign_prod, out_valid, overflow;

  min2_stream_finder #(.W(6), .LANES(8), .MAX_BEATS(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last), .x(x), .sgn(sgn),
    .min1(min1), .min2(min2), .idx(idx), .sign_prod(sign_prod),
    .out_valid(out_valid), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    cn_min2_t r;
    bit s;
    bit ov;
  } exp_t;

  exp_t q[$];
  int fm[$];
  int fb = 0;
  bit fs = 1'b0;
  int cyc = 0;
  int passed = 0;
  int total = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    else passed++;
  endtask

  // whole-frame view: smallest magnitude at lowest index, second smallest over the rest
  task automatic model(input logic [39:0] xv, input logic [7:0] s, input bit last, input int due);
    exp_t e;
    int best, m2;
    for (int k = 0; k < LANES; k++) fm.push_back(int'(xv[k*5 +: 5]));
    fs ^= ^s;
    fb++;
    if (last || fb == MAXB) begin
      best = 0;
      for (int i = 1; i < fm.size(); i++) if (fm[i] < fm[best]) best = i;
      m2 = 999;
      for (int i = 0; i < fm.size(); i++) if (i != best && fm[i] < m2) m2 = fm[i];
      e.due = due;
      e.r.min1 = 5'(fm[best]);
      e.r.min2 = 5'(m2);
      e.r.idx = 5'(best);
      e.s = fs;
      e.ov = !last;
      q.push_back(e);
      fm.delete();
      fb = 0;
      fs = 1'b0;
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    if (q.size() > 0 && q[0].due == cyc) begin
      chk("out_valid", 32'(out_valid), 1);
      chk("min1", 32'(min1), 32'(q[0].r.min1));
      chk("min2", 32'(min2), 32'(q[0].r.min2));
      chk("idx", 32'(idx), 32'(q[0].r.idx));
      chk("sign_prod", 32'(sign_prod), 32'(q[0].s));
      chk("overflow", 32'(overflow), 32'(q[0].ov));
      void'(q.pop_front());
    end else begin
      chk("idle_valid", 32'(out_valid), 0);
      chk("idle_ovf", 32'(overflow), 0);
    end
  end

  task automatic beat(input logic [39:0] xv, input logic [7:0] s, input bit last);
    @(negedge clk);
    in_valid = 1'b1;
    x = xv;
    sgn = s;
    in_last = last;
    model(xv, s, last, cyc + 3);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_last = 1'b0;
      x = 40'($urandom());
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    q.delete();
    fm.delete();
    fb = 0;
    fs = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [39:0] fill(input int v, input int lane, input int lv);
    logic [39:0] r;
    for (int k = 0; k < LANES; k++) r[k*5 +: 5] = 5'(k == lane ? lv : v);
    return r;
  endfunction

  task automatic expect_out(input int m1, input int m2, input int i, input bit s);
    idle(3);
    chk("hold_min1", 32'(min1), 32'(m1));
    chk("hold_min2", 32'(min2), 32'(m2));
    chk("hold_idx", 32'(idx), 32'(i));
    chk("hold_sign", 32'(sign_prod), 32'(s));
  endtask

  initial begin
    logic [39:0] xv;
    do_reset();
    chk("rst_min1", 32'(min1), 0);
    chk("rst_min2", 32'(min2), 0);
    chk("rst_idx", 32'(idx), 0);
    chk("rst_sign", 32'(sign_prod), 0);
    chk("rst_valid", 32'(out_valid), 0);
    xv = {5'd8, 5'd11, 5'd2, 5'd30, 5'd4, 5'd17, 5'd4, 5'd9};
    beat(xv, 8'h00, 1'b1);
    expect_out(2, 4, 5, 1'b0);
    beat(fill(7, 0, 7), 8'hFF, 1'b1);
    expect_out(7, 7, 0, 1'b0);
    beat(fill(20, 3, 6), 8'h01, 1'b0);
    beat(fill(25, 6, 3), 8'h03, 1'b1);
    expect_out(3, 6, 14, 1'b1);
    beat(fill(20, 3, 6), 8'h01, 1'b0);
    idle(2);
    beat(fill(25, 6, 3), 8'h03, 1'b1);
    beat(fill(31, 0, 1), 8'h00, 1'b1);
    expect_out(1, 31, 0, 1'b0);
    beat(fill(20, 0, 20), 8'h00, 1'b0);
    beat(fill(20, 0, 20), 8'h00, 1'b0);
    beat(fill(20, 1, 5), 8'h00, 1'b0);
    beat(fill(20, 0, 20), 8'h00, 1'b0);
    beat(fill(10, 0, 10), 8'h00, 1'b1);
    expect_out(10, 10, 0, 1'b0);
    beat(fill(20, 2, 0), 8'h00, 1'b0);
    do_reset();
    beat(fill(31, 4, 3), 8'h00, 1'b1);
    expect_out(3, 31, 4, 1'b0);
    for (int f = 0; f < 300; f++) begin
      int lim;
      lim = $urandom_range(0, 1) == 0 ? 3 : 31;
      for (int k = 0; k < LANES; k++) xv[k*5 +: 5] = 5'($urandom_range(0, lim));
      beat(xv, 8'($urandom()), $urandom_range(0, 2) == 0);
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
      if ($urandom_range(0, 60) == 0) do_reset();
    end
    idle(1);
    for (int i = 0; i < 20 && q.size() > 0; i++) idle(1);
    if (q.size() > 0) chk("drain_timeout", 32'(q.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end
endmodule
